// File: rtl/mdu_pipe_param.sv
// mdu_pipe_param: parametrised HI/LO multiply/divide unit for the E stage.
// Multi-cycle ops (MULT*, MADD*, MSUB*, DIV*) compute at launch into shadow
// registers and commit to HI/LO after a fixed latency; MTHI/MTLO write at once.
// An exception cancel discards the in-flight result so HI/LO are never corrupted.
module mdu_pipe_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] acc, prod_s, prod_u, res;
    logic [WIDTH-1:0]   q_s, r_s;
    logic               is_mdu, is_div;

    // Launch datapath: full {hi,lo} result for the op presented this cycle
    always_comb begin
        acc    = {hi_q, lo_q};
        prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        q_s    = $signed(a) / $signed(b);
        r_s    = $signed(a) % $signed(b);
        res    = '0;
        is_mdu = 1'b1;
        is_div = 1'b0;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_MADD:  res = acc + prod_s;
            OP_MADDU: res = acc + prod_u;
            OP_MSUB:  res = acc - prod_s;
            OP_MSUBU: res = acc - prod_u;
            OP_DIV: begin
                is_div = 1'b1;
                if (b == '0)
                    res = {a, {WIDTH{1'b1}}};
                else if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1)
                    res = {{WIDTH{1'b0}}, a};
                else
                    res = {r_s, q_s};
            end
            OP_DIVU: begin
                is_div = 1'b1;
                if (b == '0)
                    res = {a, {WIDTH{1'b1}}};
                else
                    res = {a % b, a / b};
            end
            default: is_mdu = 1'b0;
        endcase
    end

    // State register: async reset clears everything including any pending result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            done_q  <= done_d;
        end
    end

    // Next state: launch / count down / commit, with cancel overriding a commit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    if (is_mdu) begin
                        state_d            = S_BUSY;
                        cnt_d              = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        {sh_hi_d, sh_lo_d} = res;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_BUSY: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sh_hi_d = '0;
                    sh_lo_d = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    hi_d    = sh_hi_q;
                    lo_d    = sh_lo_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are straight from registers
    always_comb begin
        busy = (state_q == S_BUSY);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_mdu_pipe_param.sv
// tb_mdu_pipe_param: table-driven and randomized checks of mdu_pipe_param
// against a plain-arithmetic reference model of HI/LO.
module tb_mdu_pipe_param;

    localparam int W    = 32;
    localparam int MULC = 5;
    localparam int DIVC = 10;
    localparam int WIN  = DIVC + 4;

    logic         clk, reset, start, cancel, busy, done;
    logic [3:0]   op;
    logic [W-1:0] a, b, hi, lo;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] m_hi, m_lo;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, ph, pl, eh, el;
        int           nb;
        string        name;
    } vec_t;

    vec_t tbl[$];

    mdu_pipe_param #(
        .WIDTH(W),
        .MUL_CYCLES(MULC),
        .DIV_CYCLES(DIVC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .cancel(cancel),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] xa, xb, ph, pl, eh, el,
                                input int nb, input string name);
        vec_t v;
        v.op = o; v.a = xa; v.b = xb; v.ph = ph; v.pl = pl;
        v.eh = eh; v.el = el; v.nb = nb; v.name = name;
        return v;
    endfunction

    // Reference: HI/LO after the op, and how many cycles busy should be high
    function automatic void model(input logic [3:0] o, input logic [W-1:0] xa, xb, h, l,
                                  output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output int nb);
        longint          sa, sb;
        longint unsigned ua, ub, acc, r;
        sa  = longint'($signed(xa));
        sb  = longint'($signed(xb));
        ua  = {32'b0, xa};
        ub  = {32'b0, xb};
        acc = {h, l};
        r   = acc;
        nb  = 0;
        case (o)
            4'd0: begin r = sa * sb;       nb = MULC; end
            4'd1: begin r = ua * ub;       nb = MULC; end
            4'd4: begin r = acc + sa * sb; nb = MULC; end
            4'd5: begin r = acc + ua * ub; nb = MULC; end
            4'd6: begin r = acc - sa * sb; nb = MULC; end
            4'd7: begin r = acc - ua * ub; nb = MULC; end
            4'd2: begin
                nb = DIVC;
                if (xb == 0) r = {xa, 32'hFFFFFFFF};
                else         r = {32'(sa % sb), 32'(sa / sb)};
            end
            4'd3: begin
                nb = DIVC;
                if (xb == 0) r = {xa, 32'hFFFFFFFF};
                else         r = {32'(ua % ub), 32'(ua / ub)};
            end
            4'd8: r = {xa, l};
            4'd9: r = {h, xa};
            default: r = acc;
        endcase
        {eh, el} = r;
    endfunction

    // Launch one op at the next edge, optionally cancel on busy cycle cancel_at
    task automatic exec(input logic [3:0] o, input logic [W-1:0] xa, xb, input int cancel_at,
                        input logic [W-1:0] eh, el, input int eb, input string name);
        int busy_n   = 0;
        int done_n   = 0;
        int done_at  = 0;
        int hold_bad = 0;
        int exp_done;
        exp_done = (eb > 0 && cancel_at == 0) ? 1 : 0;
        op = o; a = xa; b = xb; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 1; i <= WIN; i++) begin
            if (i == cancel_at) cancel = 1'b1;
            @(negedge clk);
            if (busy === 1'b1) begin
                busy_n++;
                if (hi !== m_hi || lo !== m_lo) hold_bad++;
            end
            if (done === 1'b1) begin
                done_n++;
                done_at = i;
            end
            @(posedge clk); #1 cancel = 1'b0;
        end
        chk({name, "/busy_cycles"}, busy_n, eb);
        chk({name, "/done_pulses"}, done_n, exp_done);
        if (exp_done == 1) chk({name, "/done_cycle"}, done_at, eb + 1);
        chk({name, "/hold_while_busy"}, hold_bad, 0);
        chk({name, "/hi"}, hi, eh);
        chk({name, "/lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic set_hilo(input logic [W-1:0] h, l);
        exec(4'd8, h, '0, 0, h, m_lo, 0, "mthi");
        exec(4'd9, l, '0, 0, m_hi, l, 0, "mtlo");
    endtask

    // start together with cancel must launch nothing
    task automatic start_cancel(input logic [3:0] o, input logic [W-1:0] xa, input string name);
        int busy_n = 0;
        int done_n = 0;
        op = o; a = xa; b = 32'd3; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1 start = 1'b0; cancel = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) done_n++;
            @(posedge clk); #1;
        end
        chk({name, "/busy_cycles"}, busy_n, 0);
        chk({name, "/done_pulses"}, done_n, 0);
        chk({name, "/hi"}, hi, m_hi);
        chk({name, "/lo"}, lo, m_lo);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;

        tbl.push_back(mk(4'd0, 32'hFFFFFFFE, 32'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, MULC, "mult_neg"));
        tbl.push_back(mk(4'd3, 32'd7, 32'd0, 0, 0, 32'd7, 32'hFFFFFFFF, DIVC, "divu_by0"));
        tbl.push_back(mk(4'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, DIVC, "div_m7_2"));
        tbl.push_back(mk(4'd5, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 32'd2, 32'd0, MULC, "maddu_carry"));
        tbl.push_back(mk(4'd7, 32'd1, 32'd1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, MULC, "msubu_wrap"));
        tbl.push_back(mk(4'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'd0, 32'h80000000, DIVC, "div_ovf"));
        tbl.push_back(mk(4'd2, 32'hFFFFFFFB, 32'd0, 0, 0, 32'hFFFFFFFB, 32'hFFFFFFFF, DIVC, "div_by0"));
        tbl.push_back(mk(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, MULC, "multu_max"));
        tbl.push_back(mk(4'd4, 32'hFFFFFFFF, 32'd3, 0, 32'd10, 32'd0, 32'd7, MULC, "madd_neg"));
        tbl.push_back(mk(4'd6, 32'hFFFFFFFE, 32'd3, 0, 0, 32'd0, 32'd6, MULC, "msub_neg"));
        tbl.push_back(mk(4'd2, 32'd7, 32'hFFFFFFFE, 0, 0, 32'd1, 32'hFFFFFFFD, DIVC, "div_7_m2"));
        tbl.push_back(mk(4'd10, 32'h5, 32'h6, 32'h12, 32'h34, 32'h12, 32'h34, 0, "undef_op"));
        tbl.push_back(mk(4'd8, 32'hABCD, 32'h6, 32'h12, 32'h34, 32'hABCD, 32'h34, 0, "mthi"));
        tbl.push_back(mk(4'd6, 32'd1, 32'd1, 32'h80000000, 0, 32'h7FFFFFFF, 32'hFFFFFFFF, MULC, "msub_borrow"));
        tbl.push_back(mk(4'd3, 32'hFFFFFFFF, 32'd16, 0, 0, 32'hF, 32'h0FFFFFFF, DIVC, "divu_16"));

        // reset state
        #12;
        chk("reset/busy", busy, 0);
        chk("reset/done", done, 0);
        chk("reset/hi", hi, 0);
        chk("reset/lo", lo, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            set_hilo(tbl[i].ph, tbl[i].pl);
            exec(tbl[i].op, tbl[i].a, tbl[i].b, 0, tbl[i].eh, tbl[i].el, tbl[i].nb, tbl[i].name);
        end

        // cancel mid-op, on the commit edge, and on the first busy cycle
        set_hilo(32'h0, 32'h55);
        exec(4'd2, 32'hFFFFFFF9, 32'd2, 3, 32'h0, 32'h55, 3, "cancel_div3");
        exec(4'd2, 32'hFFFFFFF9, 32'd2, DIVC, 32'h0, 32'h55, DIVC, "cancel_div_last");
        exec(4'd0, 32'd3, 32'd4, MULC, 32'h0, 32'h55, MULC, "cancel_mul_last");
        exec(4'd0, 32'd3, 32'd4, 1, 32'h0, 32'h55, 1, "cancel_mul_first");
        exec(4'd0, 32'd3, 32'd4, 0, 32'h0, 32'd12, MULC, "after_cancel");

        start_cancel(4'd8, 32'h99, "sc_mthi");
        start_cancel(4'd9, 32'h99, "sc_mtlo");
        start_cancel(4'd0, 32'h99, "sc_mult");
        start_cancel(4'd2, 32'h99, "sc_div");

        // async reset mid-MULT, off the clock edge
        set_hilo(32'h1234, 32'h5678);
        op = 4'd0; a = 32'd7; b = 32'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("rst_mid/busy", busy, 0);
        chk("rst_mid/done", done, 0);
        chk("rst_mid/hi", hi, 0);
        chk("rst_mid/lo", lo, 0);
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1 reset = 1'b0;
        begin
            int done_n = 0;
            for (int i = 0; i < WIN; i++) begin
                @(negedge clk);
                if (done === 1'b1 || busy === 1'b1) done_n++;
                @(posedge clk); #1;
            end
            chk("rst_mid/no_commit", done_n, 0);
        end

        // async reset while idle, in the low phase of the clock
        set_hilo(32'hAAAA, 32'hBBBB);
        @(negedge clk); #2 reset = 1'b1;
        #1;
        chk("rst_idle/hi", hi, 0);
        chk("rst_idle/lo", lo, 0);
        #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1;

        // randomized ops against the reference model
        for (int it = 0; it < 40; it++) begin
            logic [3:0]   o;
            logic [W-1:0] xa, xb, eh, el;
            int           nb, ca;
            o  = 4'($urandom_range(0, 11));
            xa = pick();
            xb = pick();
            model(o, xa, xb, m_hi, m_lo, eh, el, nb);
            ca = 0;
            if (nb > 0 && $urandom_range(0, 3) == 0) begin
                ca = $urandom_range(1, nb);
                eh = m_hi;
                el = m_lo;
                nb = ca;
            end
            exec(o, xa, xb, ca, eh, el, nb, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
